xor_stream_packer: RTL and testbench

Downstream consumer of the xor gate's single-bit result stream. It collects serial result bits LSB-first into WIDTH-bit words and buffers completed words in a DEPTH-entry first-word-fall-through FIFO. Each word carries its parity. Words leave through a valid/ready output handshake toward the cache/FIFO datapath. The serial input has no backpressure, so words that complete while the FIFO is full are dropped and flagged.

---
 rtl/xor_stream_packer_if.sv | 24 ++
 rtl/xor_stream_packer.sv | 63 ++++++
 tb/tb_xor_stream_packer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/xor_stream_packer_if.sv
// xor_stream_packer_if: serial-in / packed-word-out bus for xor_stream_packer
interface xor_stream_packer_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
);
  logic in_bit;
  logic in_valid;
  logic flush;
  logic [WIDTH-1:0] m_data;
  logic m_parity;
  logic m_valid;
  logic m_ready;
  logic [AW:0] level;
  logic overflow;
  modport master (
    input in_bit, in_valid, flush, m_ready,
    output m_data, m_parity, m_valid, level, overflow
  );
  modport slave (
    output in_bit, in_valid, flush, m_ready,
    input m_data, m_parity, m_valid, level, overflow
  );
endinterface

// File: rtl/xor_stream_packer.sv
// xor_stream_packer: packs serial xor result bits LSB-first into words with parity, FWFT FIFO out
module xor_stream_packer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(WIDTH)
) (
  input logic clk,
  input logic rst,
  xor_stream_packer_if.master s
);
  logic [CW-1:0] bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] word;
  logic [WIDTH:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0] level;
  logic overflow;
  logic last;
  logic push;
  logic pop;
  logic wr_en;
  always_comb begin
    word = shreg;
    if (s.in_valid) word[bit_cnt] = s.in_bit;
    last = s.in_valid && bit_cnt == CW'(WIDTH - 1);
    push = last || (s.flush && (s.in_valid || bit_cnt != '0));
    pop = s.m_valid && s.m_ready;
    wr_en = push && (level != (AW+1)'(DEPTH) || pop);
  end
  // shreg is cleared on every push so a flushed partial word is zero-padded
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
      shreg <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      level <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        bit_cnt <= '0;
        shreg <= '0;
      end else if (s.in_valid) begin
        bit_cnt <= bit_cnt + 1'b1;
        shreg <= word;
      end
      if (wr_en) begin
        mem[wr_ptr] <= {^word, word};
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      level <= (wr_en && !pop) ? level + 1'b1 : (pop && !wr_en) ? level - 1'b1 : level;
      if (push && !wr_en) overflow <= 1'b1;
    end
  end
  assign s.m_data = mem[rd_ptr][WIDTH-1:0];
  assign s.m_parity = mem[rd_ptr][WIDTH];
  assign s.m_valid = level != '0;
  assign s.level = level;
  assign s.overflow = overflow;
endmodule

// File: tb/tb_xor_stream_packer.sv
// tb_xor_stream_packer: scoreboard bench, reference packer/FIFO model feeds an expected-word queue
module tb_xor_stream_packer;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  logic clk = 0;
  logic rst = 1;
  int n_chk = 0;
  int n_fail = 0;
  bit mon_en = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] msh;
  logic [WIDTH-1:0] mw;
  logic [WIDTH-1:0] last_pop;
  int mcnt;
  int mlevel;
  bit movf;
  bit mpop;
  bit mpush;
  xor_stream_packer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  xor_stream_packer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .s(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  // reference model: pop before push so a full FIFO with a pop still accepts the word
  always @(posedge clk) begin
    if (rst) begin
      mcnt = 0;
      msh = '0;
      mlevel = 0;
      movf = 0;
      exp_q.delete();
    end else begin
      mpop = bus.m_ready && mlevel != 0;
      mw = msh;
      if (bus.in_valid) mw[mcnt] = bus.in_bit;
      mpush = (bus.in_valid && mcnt == WIDTH - 1) || (bus.flush && (bus.in_valid || mcnt != 0));
      if (mpop) begin
        last_pop = exp_q.pop_front();
        mlevel--;
      end
      if (mpush) begin
        if (mlevel < DEPTH) begin
          exp_q.push_back(mw);
          mlevel++;
        end else movf = 1;
        msh = '0;
        mcnt = 0;
      end else if (bus.in_valid) begin
        msh = mw;
        mcnt++;
      end
    end
  end
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("level", 32'(bus.level), 32'(mlevel));
      chk("overflow", 32'(bus.overflow), 32'(movf));
      chk("m_valid", 32'(bus.m_valid), 32'(mlevel != 0));
      if (mlevel != 0 && exp_q.size() != 0) begin
        chk("m_data", 32'(bus.m_data), 32'(exp_q[0]));
        chk("m_parity", 32'(bus.m_parity), 32'(^exp_q[0]));
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic b, input logic f);
    bus.in_bit = b;
    bus.in_valid = 1;
    bus.flush = f;
    tick();
    bus.in_valid = 0;
    bus.flush = 0;
  endtask
  task automatic send_word(input logic [WIDTH-1:0] w);
    for (int i = 0; i < WIDTH; i++) send(w[i], 0);
  endtask
  task automatic do_flush();
    bus.flush = 1;
    tick();
    bus.flush = 0;
  endtask
  task automatic drain(input int n);
    bus.m_ready = 1;
    repeat (n) tick();
    bus.m_ready = 0;
  endtask
  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
  endtask
  initial begin
    logic [7:0] pat;
    bus.in_bit = 0;
    bus.in_valid = 0;
    bus.flush = 0;
    bus.m_ready = 0;
    repeat (2) tick();
    rst = 0;
    mon_en = 1;
    chk("rst_level", 32'(bus.level), 0);
    chk("rst_valid", 32'(bus.m_valid), 0);
    chk("rst_ovf", 32'(bus.overflow), 0);
    pat = 8'b0100_1101;
    for (int i = 0; i < 8; i++) send(pat[i], 0);
    chk("basic_valid", 32'(bus.m_valid), 1);
    chk("basic_data", 32'(bus.m_data), 32'h4D);
    chk("basic_parity", 32'(bus.m_parity), 0);
    chk("basic_level", 32'(bus.level), 1);
    drain(1);
    chk("basic_drained", 32'(bus.level), 0);
    for (int i = 0; i < 16; i++) send(i % 4 == 1 || i % 4 == 2, 0);
    chk("gate_level", 32'(bus.level), 2);
    chk("gate_data", 32'(bus.m_data), 32'h66);
    chk("gate_parity", 32'(bus.m_parity), 0);
    drain(3);
    chk("gate_drained", 32'(bus.level), 0);
    for (int w = 1; w <= 5; w++) send_word(8'(w));
    chk("ovf_level", 32'(bus.level), 4);
    chk("ovf_flag", 32'(bus.overflow), 1);
    chk("ovf_head", 32'(bus.m_data), 32'h01);
    drain(5);
    chk("ovf_last", 32'(last_pop), 32'h04);
    chk("ovf_empty", 32'(bus.m_valid), 0);
    chk("ovf_sticky", 32'(bus.overflow), 1);
    do_reset();
    for (int w = 16; w < 20; w++) send_word(8'(w));
    pat = 8'hA5;
    for (int i = 0; i < 7; i++) send(pat[i], 0);
    bus.m_ready = 1;
    send(pat[7], 0);
    bus.m_ready = 0;
    chk("full_pp_level", 32'(bus.level), 4);
    chk("full_pp_ovf", 32'(bus.overflow), 0);
    chk("full_pp_head", 32'(bus.m_data), 32'h11);
    drain(4);
    chk("full_pp_last", 32'(last_pop), 32'hA5);
    repeat (3) send(1, 0);
    do_flush();
    chk("flush_data", 32'(bus.m_data), 32'h07);
    chk("flush_parity", 32'(bus.m_parity), 1);
    chk("flush_level", 32'(bus.level), 1);
    do_flush();
    chk("flush_noop", 32'(bus.level), 1);
    drain(1);
    send(1, 0);
    send(0, 0);
    send(1, 1);
    chk("flush_v_data", 32'(bus.m_data), 32'h05);
    chk("flush_v_parity", 32'(bus.m_parity), 0);
    drain(1);
    repeat (5) send(1, 0);
    do_reset();
    send_word(8'hFF);
    chk("midrst_level", 32'(bus.level), 1);
    chk("midrst_data", 32'(bus.m_data), 32'hFF);
    chk("midrst_parity", 32'(bus.m_parity), 0);
    chk("midrst_ovf", 32'(bus.overflow), 0);
    drain(2);
    chk("final_empty", 32'(bus.m_valid), 0);
    mon_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
